// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: architectural register
// names, default register count and the controller state encoding.
package reg_file_mp_pkg;

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2,
    S0, S1, A0, A1, A2, A3, A4, A5,
    A6, A7, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, T3, T4, T5, T6
  } regName_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Outstanding-write tracker: one pending bit per register, set on issue and
// cleared on writeback (set wins on a same-cycle collision), with NUM_RD query ports.
module rf_scoreboard #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned NUM_RD    = 2
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic                                  set_i,
  input  logic [$clog2(REG_COUNT)-1:0]          set_addr_i,
  input  logic                                  clr_i,
  input  logic [$clog2(REG_COUNT)-1:0]          clr_addr_i,
  input  logic [NUM_RD*$clog2(REG_COUNT)-1:0]   q_addr_i,
  output logic [NUM_RD-1:0]                     q_pend_c
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0] pend_q, pend_d;

  // Clear first so a simultaneous issue to the same register leaves it pending
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    if (set_i) pend_d[set_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    q_pend_c = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      q_pend_c[p] = pend_q[q_addr_i[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a post-reset initialisation sweep and
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module reg_file_mp #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            REG_COUNT  = 32,
  parameter int unsigned            NUM_RD     = 2,
  parameter int unsigned            SP_IDX     = 2,
  parameter logic [DATA_WIDTH-1:0]  SP_INIT    = DATA_WIDTH'(32'hff0)
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic [NUM_RD*$clog2(REG_COUNT)-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_RD-1:0]                     rd_pend,
  input  logic                                  wen,
  input  logic [$clog2(REG_COUNT)-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  pend_set,
  input  logic [$clog2(REG_COUNT)-1:0]          pend_addr,
  output logic                                  ready
);

  import reg_file_mp_pkg::*;

  localparam int unsigned AW = $clog2(REG_COUNT);

  rf_state_t             state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  run_c;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
  logic [NUM_RD-1:0]     pend_c;

  assign run_c = (state_q == RUN);
  assign ready = ready_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // The sweep owns the single write port during INIT; traffic owns it in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (cnt_q == AW'(SP_IDX)) ? SP_INIT : '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(REG_COUNT - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        mem_we = wen && (wr_addr != '0);
      end
      default: state_d = INIT;
    endcase
  end

  // Data array deliberately has no reset; the sweep establishes its contents
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  rf_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_RD    (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .rstN       (rstN),
    .set_i      (run_c && pend_set && (pend_addr != '0)),
    .set_addr_i (pend_addr),
    .clr_i      (run_c && wen),
    .clr_addr_i (wr_addr),
    .q_addr_i   (rd_addr),
    .q_pend_c   (pend_c)
  );

  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_pend = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      ra = rd_addr[p*AW +: AW];
      if (run_c && (ra != '0)) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
        rd_pend[p]                          = pend_c[p];
`ifdef REGFILE_BYPASS_EN
        if (wen && (wr_addr != '0) && (ra == wr_addr)) begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data;
          rd_pend[p]                          = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised self-checking bench for reg_file_mp against a behavioural model
// of the register file, its init sweep and its pending bits.
module tb_reg_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned RC = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstN;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pend;
  logic              wen;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              pend_set;
  logic [AW-1:0]     pend_addr;
  logic              ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [RC];
  bit            m_pend [RC];
  int            m_edges;
  bit            m_ready;

  reg_file_mp dut (
    .clk       (clk),
    .rstN      (rstN),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .wen       (wen),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_ready = 1'b0;
    for (int k = 0; k < int'(RC); k++) m_pend[k] = 1'b0;
  endtask

  // One rising edge of the reference: count sweep edges, then apply traffic
  task automatic model_edge();
    if (!rstN) return;
    if (!m_ready) begin
      m_edges++;
      if (m_edges == int'(RC)) begin
        m_ready = 1'b1;
        for (int k = 0; k < int'(RC); k++) m_mem[k] = (k == 2) ? 32'h0000_0ff0 : 32'h0;
      end
    end else begin
      if (wen) begin
        if (wr_addr != 0) m_mem[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_reads(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    #1;
    chk({tag, "/ready"}, 64'(ready), 64'(m_ready));
    for (int p = 0; p < int'(NR); p++) begin
      a = rd_addr[p*AW +: AW];
      if (!m_ready || a == 0) begin
        ed = '0; ep = 1'b0;
      end else if (BYP && wen && wr_addr != 0 && a == wr_addr) begin
        ed = wr_data; ep = 1'b0;
      end else begin
        ed = m_mem[a]; ep = m_pend[a];
      end
      chk($sformatf("%s/data%0d[a=%0d]", tag, p, a), 64'(rd_data[p*DW +: DW]), 64'(ed));
      chk($sformatf("%s/pend%0d[a=%0d]", tag, p, a), 64'(rd_pend[p]), 64'(ep));
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(RC));
  endtask

  initial begin
    rstN = 1'b0; wen = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0; rd_addr = '0;
    for (int k = 0; k < int'(RC); k++) m_mem[k] = '0;
    model_reset();
    #12;
    check_reads("reset");

    @(negedge clk);
    rstN = 1'b1;
    wait_ready("init_edges");
    rd_addr = {5'd5, 5'd2};
    check_reads("init_vals");
    chk("sp_init", 64'(rd_data[31:0]), 64'h0000_0ff0);
    chk("reg5_zero", 64'(rd_data[63:32]), 64'h0);

    wen = 1'b1; wr_addr = 5'd0; wr_data = 32'hdead_beef; rd_addr = {5'd0, 5'd0};
    check_reads("w0_pre");
    tick();
    wen = 1'b0;
    check_reads("w0_post");
    chk("reg0_zero", 64'(rd_data[31:0]), 64'h0);

    wen = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    tick();
    wen = 1'b0; rd_addr = {5'd7, 5'd7};
    check_reads("w7");
    chk("reg7_p0", 64'(rd_data[31:0]), 64'h1234_5678);
    chk("reg7_p1", 64'(rd_data[63:32]), 64'h1234_5678);

    pend_set = 1'b1; pend_addr = 5'd9;
    tick();
    pend_set = 1'b0; rd_addr = {5'd9, 5'd9};
    check_reads("pset9");
    chk("pend9_set", 64'(rd_pend[0]), 64'h1);
    wen = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    tick();
    wen = 1'b0;
    check_reads("pclr9");
    chk("pend9_clr", 64'(rd_pend[1]), 64'h0);
    wen = 1'b1; pend_set = 1'b1;
    tick();
    wen = 1'b0; pend_set = 1'b0;
    check_reads("pboth9");
    chk("pend9_setwins", 64'(rd_pend[0]), 64'h1);

    wen = 1'b1; wr_addr = 5'd4; wr_data = 32'ha5a5_a5a5; rd_addr = {5'd4, 5'd4};
    #1;
    chk("bypass4", 64'(rd_data[31:0]), BYP ? 64'ha5a5_a5a5 : 64'h0);
    check_reads("bypass4_model");
    tick();
    wen = 1'b0;

    for (int i = 0; i < 400; i++) begin
      wen       = ($urandom_range(0, 1) == 1);
      wr_addr   = rnd_addr();
      wr_data   = $urandom;
      pend_set  = ($urandom_range(0, 2) == 0);
      pend_addr = ($urandom_range(0, 3) == 0) ? wr_addr : rnd_addr();
      rd_addr   = {rnd_addr(), ($urandom_range(0, 2) == 0) ? wr_addr : rnd_addr()};
      check_reads($sformatf("rnd%0d", i));
      tick();
    end
    wen = 1'b0; pend_set = 1'b0;

    rstN = 1'b0;
    model_reset();
    check_reads("rst2");
    @(negedge clk);
    rstN = 1'b1;
    repeat (10) tick();
    rstN = 1'b0;
    model_reset();
    check_reads("rst_mid");
    @(negedge clk);
    rstN = 1'b1;
    wen = 1'b1; wr_addr = 5'd5; wr_data = 32'hffff_ffff;
    pend_set = 1'b1; pend_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    wait_ready("restart_edges");
    wen = 1'b0; pend_set = 1'b0;
    check_reads("post_restart");
    chk("reg5_untouched", 64'(rd_data[31:0]), 64'h0);
    chk("pend5_untouched", 64'(rd_pend[0]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers (power of 2, min 4).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter SP_IDX, default 2, register index initialised to SP_INIT.
REQ-005 SHALL have parameter SP_INIT, default 32'hff0, stack pointer initial value.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rstN  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rd_addr  input  NUM_RD x log2(REG_COUNT)  read addresses.
REQ-009 SHALL have port rd_data  output  NUM_RD x DATA_WIDTH  read data, combinational from rd_addr.
REQ-010 SHALL have port rd_pend  output  NUM_RD  1 = addressed register has an outstanding write.
REQ-011 SHALL have port wen  input  1  write enable.
REQ-012 SHALL have port wr_addr  input  log2(REG_COUNT)  write address.
REQ-013 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-014 SHALL have port pend_set  input  1  mark pend_addr as having an outstanding write (issue).
REQ-015 SHALL have port pend_addr  input  log2(REG_COUNT)  register marked by pend_set.
REQ-016 SHALL have port ready  output  1  1 = initialisation complete, block accepts traffic.

Function
REQ-017 SHALL implement FSM states INIT and RUN; INIT entered on reset, RUN entered after the sweep completes; RUN left only by reset.
REQ-018 In INIT, SHALL write register k on the k-th rising edge after rstN deassertion (k = 0..REG_COUNT-1): value SP_INIT if k == SP_IDX, else 0.
REQ-019 SHALL assert ready on the edge writing register REG_COUNT-1 (ready high after exactly REG_COUNT edges).
REQ-020 In INIT, SHALL ignore wen and pend_set, drive rd_data = 0 and rd_pend = 0.
REQ-021 In RUN, wen = 1 SHALL write wr_data to wr_addr on the rising edge; wr_addr == 0 writes are discarded.
REQ-022 Register 0 SHALL always read 0 and never report pending.
REQ-023 pend_set = 1 in RUN SHALL set the pending bit of pend_addr (nonzero) on the rising edge.
REQ-024 wen = 1 in RUN SHALL clear the pending bit of wr_addr on the rising edge.
REQ-025 If pend_set and wen target the same address in one cycle, the pending bit SHALL end set (set wins).
REQ-026 Read ports SHALL be fully independent; any ports may read the same address simultaneously.

Reset
REQ-027 rstN low SHALL asynchronously force state INIT, sweep counter 0, ready 0, all pending bits 0.
REQ-028 The data array SHALL NOT be reset directly; its contents are established only by the INIT sweep.
REQ-029 Reset asserted mid-sweep or in RUN SHALL restart the sweep from register 0 after deassertion.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined, a read port whose rd_addr equals wr_addr (nonzero) while wen = 1 in RUN SHALL return wr_data and rd_pend = 0 in the same cycle.
REQ-031 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write array value and the pre-write pending bit.

Structure
REQ-032 The FSM state enum (rf_state_t: INIT, RUN) SHALL be added to package definitions next to the existing regName_t and REG_COUNT.
REQ-033 Pending-bit tracking SHALL be a sub-module rf_scoreboard (pending vector, set/clear priority, NUM_RD query ports).

Verification
REQ-034 Reset release, idle: ready rises after exactly 32 edges; then reg2 reads 0x00000ff0 and reg5 reads 0.
REQ-035 wen with wr_addr=0, wr_data=0xdeadbeef: reg0 still reads 0; wen with wr_addr=7, wr_data=0x12345678: both ports read 0x12345678 on addr 7.
REQ-036 pend_set addr 9, next cycle rd_pend=1 on addr 9; wen addr 9 -> rd_pend=0 next cycle; set and wen to addr 9 in one cycle -> rd_pend=1.
REQ-037 Bypass build: wen addr 4, data 0xa5a5a5a5, rd_addr 4 same cycle -> rd_data 0xa5a5a5a5; non-bypass build -> old value.
REQ-038 rstN pulsed low at sweep edge 10: ready stays 0, sweep restarts, ready rises 32 edges after release; wen during INIT has no effect.
